rom_readback: RTL and testbench

//  Read-side counterpart of the ioctl ROM download path: serves MiSTer ioctl upload reads from the Blue Print ROM set.

---
 rtl/rom_readback_if.sv | 24 ++
 rtl/rom_readback.sv | 138 +++++++++++++
 tb/tb_rom_readback.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rom_readback_if.sv
// Upload-read bus between the HPS ioctl port, rom_readback and port B of the ROM dprams.
// Handshake: ioctl_rd is a one-cycle request, taken only while the reader is idle; ioctl_wait stays high from acceptance until ioctl_din holds the byte.
interface rom_readback_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [11:0] ADDR_RB;
    logic [9:0]  CS_RB;
    logic [79:0] DATA_RB;
    logic [15:0] CRC;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, DATA_RB,
        output ioctl_din, ioctl_wait, ADDR_RB, CS_RB, CRC
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, DATA_RB,
        input  ioctl_din, ioctl_wait, ADDR_RB, CS_RB, CRC
    );
endinterface

// File: rtl/rom_readback.sv
// Serves ioctl upload reads from the 10 x 4KB Blue Print ROM map through the dpram port B.
// Optional running CRC-16/CCITT of delivered bytes is enabled with ROM_READBACK_CRC_EN.
module rom_readback #(
    parameter int unsigned RD_LAT   = 1,
    parameter logic [7:0]  UL_INDEX = 8'd0,
    parameter logic [7:0]  FILL     = 8'hFF
) (
    input  logic           CLK_DL,
    input  logic           RESET_N,
    rom_readback_if.slave  io,
    output logic [1:0]     o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

    state_t      r_state, w_state_nxt;
    logic [24:0] r_addr, w_addr_nxt;
    logic [7:0]  r_din, w_din_nxt;
    logic        r_wait, w_wait_nxt;
    logic [11:0] r_addr_rb, w_addr_rb_nxt;
    logic [9:0]  r_cs_rb, w_cs_rb_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic        w_capture;
    logic [9:0]  w_onehot;
    logic [7:0]  w_byte;

    // Regions 10 and above select no ROM and deliver FILL with unchanged timing.
    always_comb begin
        w_onehot = 10'd0;
        w_byte   = FILL;
        for (int i = 0; i < 10; i++) begin
            if (r_addr[24:12] == 13'(i)) begin
                w_onehot[i] = 1'b1;
                w_byte      = io.DATA_RB[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_din_nxt     = r_din;
        w_wait_nxt    = r_wait;
        w_addr_rb_nxt = r_addr_rb;
        w_cs_rb_nxt   = r_cs_rb;
        w_cnt_nxt     = r_cnt;
        w_capture     = 1'b0;
        if (r_state != S_IDLE && !io.ioctl_upload) begin
            // Session ended mid-read: drop it, keep the last delivered byte.
            w_state_nxt = S_IDLE;
            w_wait_nxt  = 1'b0;
            w_cs_rb_nxt = 10'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io.ioctl_rd && io.ioctl_upload && io.ioctl_index == UL_INDEX) begin
                        w_addr_nxt  = io.ioctl_addr;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_addr_rb_nxt = r_addr[11:0];
                    w_cs_rb_nxt   = w_onehot;
                    w_wait_nxt    = 1'b1;
                    w_cnt_nxt     = 2'(RD_LAT);
                    w_state_nxt   = S_WAIT;
                end
                S_WAIT: begin
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) w_state_nxt = S_CAPTURE;
                end
                S_CAPTURE: begin
                    w_din_nxt   = w_byte;
                    w_wait_nxt  = 1'b0;
                    w_cs_rb_nxt = 10'd0;
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_addr    <= 25'd0;
            r_din     <= 8'h00;
            r_wait    <= 1'b0;
            r_addr_rb <= 12'd0;
            r_cs_rb   <= 10'd0;
            r_cnt     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
            r_wait    <= w_wait_nxt;
            r_addr_rb <= w_addr_rb_nxt;
            r_cs_rb   <= w_cs_rb_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign io.ioctl_din  = r_din;
    assign io.ioctl_wait = r_wait;
    assign io.ADDR_RB    = r_addr_rb;
    assign io.CS_RB      = r_cs_rb;
    assign o_dbg_state   = r_state;

`ifdef ROM_READBACK_CRC_EN
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        end
        return x;
    endfunction

    logic        r_upload_d;
    logic [15:0] r_crc;

    // A new upload session restarts the checksum.
    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            r_upload_d <= 1'b0;
            r_crc      <= 16'hFFFF;
        end else begin
            r_upload_d <= io.ioctl_upload;
            if (io.ioctl_upload && !r_upload_d) r_crc <= 16'hFFFF;
            else if (w_capture)                 r_crc <= crc16_byte(r_crc, w_din_nxt);
        end
    end

    assign io.CRC = r_crc;
`else
    assign io.CRC = 16'hFFFF;
`endif
endmodule

// File: tb/tb_rom_readback.sv
// Directed bench for rom_readback: RD_LAT=1 and RD_LAT=3 instances fed by a registered ROM model.
module tb_rom_readback;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_readback_if if1 ();
    rom_readback_if if3 ();
    logic [1:0] dbg1, dbg3;

    rom_readback #(.RD_LAT(1), .UL_INDEX(8'd0), .FILL(8'hFF)) u_dut1 (
        .CLK_DL(clk), .RESET_N(rst_n), .io(if1), .o_dbg_state(dbg1));
    rom_readback #(.RD_LAT(3), .UL_INDEX(8'd0), .FILL(8'hFF)) u_dut3 (
        .CLK_DL(clk), .RESET_N(rst_n), .io(if3), .o_dbg_state(dbg3));

    function automatic logic [7:0] rom_byte(input int r, input logic [11:0] a);
        if (r == 5 && a == 12'h003) return 8'h5A;
        if (r == 0 && a == 12'h000) return 8'hC3;
        if (r == 9 && a == 12'hFFF) return 8'h11;
        if (r == 1 && a == 12'h000) return 8'h00;
        return 8'(r * 16) ^ a[7:0] ^ 8'h80;
    endfunction

    // dpram port-B model: registered q, one cycle after the address.
    always @(posedge clk) begin
        for (int i = 0; i < 10; i++) begin
            if1.DATA_RB[8*i +: 8] <= rom_byte(i, if1.ADDR_RB);
            if3.DATA_RB[8*i +: 8] <= rom_byte(i, if3.ADDR_RB);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One read on the RD_LAT=1 instance with cycle-exact checks of the wait pulse.
    task automatic read1(input string tag, input logic [24:0] a,
                         input logic [9:0] exp_cs, input logic [7:0] exp_din);
        if1.ioctl_addr = a;
        if1.ioctl_rd   = 1'b1;
        tick();
        if1.ioctl_rd   = 1'b0;
        chk({tag, "_wait_n"}, 32'(if1.ioctl_wait), 32'd0);
        tick();
        chk({tag, "_wait_n1"}, 32'(if1.ioctl_wait), 32'd1);
        chk({tag, "_addr_rb"}, 32'(if1.ADDR_RB), 32'(a[11:0]));
        chk({tag, "_cs_rb"}, 32'(if1.CS_RB), 32'(exp_cs));
        tick();
        chk({tag, "_wait_n2"}, 32'(if1.ioctl_wait), 32'd1);
        tick();
        chk({tag, "_wait_n3"}, 32'(if1.ioctl_wait), 32'd0);
        chk({tag, "_din"}, 32'(if1.ioctl_din), 32'(exp_din));
        chk({tag, "_cs_off"}, 32'(if1.CS_RB), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        if1.ioctl_upload = 1'b0; if1.ioctl_index = 8'd0; if1.ioctl_rd = 1'b0; if1.ioctl_addr = 25'd0;
        if3.ioctl_upload = 1'b0; if3.ioctl_index = 8'd0; if3.ioctl_rd = 1'b0; if3.ioctl_addr = 25'd0;
        repeat (3) tick();
        chk("rst_din",   32'(if1.ioctl_din),  32'h00);
        chk("rst_wait",  32'(if1.ioctl_wait), 32'd0);
        chk("rst_addr",  32'(if1.ADDR_RB),    32'd0);
        chk("rst_cs",    32'(if1.CS_RB),      32'd0);
        chk("rst_crc",   32'(if1.CRC),        32'hFFFF);
        chk("rst_state", 32'(dbg1),           32'd0);
        chk("rst_cs3",   32'(if3.CS_RB),      32'd0);
        rst_n = 1'b1;
        tick();

        // No read while upload is low.
        if1.ioctl_addr = 25'h0000; if1.ioctl_rd = 1'b1;
        tick();
        if1.ioctl_rd = 1'b0;
        tick();
        chk("noup_cs", 32'(if1.CS_RB), 32'd0);
        chk("noup_wait", 32'(if1.ioctl_wait), 32'd0);

        if1.ioctl_upload = 1'b1;
        if3.ioctl_upload = 1'b1;
        tick();

        read1("t1", 25'h5003, 10'b0000100000, 8'h5A);
        read1("t2a", 25'h0000, 10'b0000000001, 8'hC3);
        read1("t2b", 25'h9FFF, 10'b1000000000, 8'h11);
        read1("t3", 25'hA000, 10'b0000000000, 8'hFF);
        chk("t3_hold", 32'(if1.ioctl_din), 32'hFF);

        // Second strobe one cycle after the first is dropped.
        if1.ioctl_addr = 25'h5003; if1.ioctl_rd = 1'b1;
        tick();
        if1.ioctl_addr = 25'h0000;
        tick();
        if1.ioctl_rd = 1'b0;
        chk("t4_cs", 32'(if1.CS_RB), 32'b0000100000);
        tick();
        tick();
        chk("t4_wait", 32'(if1.ioctl_wait), 32'd0);
        chk("t4_din", 32'(if1.ioctl_din), 32'h5A);
        tick();
        tick();
        chk("t4_no2nd_cs", 32'(if1.CS_RB), 32'd0);
        chk("t4_no2nd_wait", 32'(if1.ioctl_wait), 32'd0);
        chk("t4_no2nd_din", 32'(if1.ioctl_din), 32'h5A);

        // Index mismatch is ignored.
        if1.ioctl_index = 8'd3; if1.ioctl_addr = 25'h0000; if1.ioctl_rd = 1'b1;
        tick();
        if1.ioctl_rd = 1'b0;
        tick();
        chk("idx_cs", 32'(if1.CS_RB), 32'd0);
        chk("idx_wait", 32'(if1.ioctl_wait), 32'd0);
        tick(); tick();
        chk("idx_din", 32'(if1.ioctl_din), 32'h5A);
        if1.ioctl_index = 8'd0;

        // RD_LAT=3: full read, then upload abort while in WAIT.
        if3.ioctl_addr = 25'h5003; if3.ioctl_rd = 1'b1;
        tick();
        if3.ioctl_rd = 1'b0;
        chk("l3_wait_n", 32'(if3.ioctl_wait), 32'd0);
        tick();
        chk("l3_wait_n1", 32'(if3.ioctl_wait), 32'd1);
        chk("l3_cs", 32'(if3.CS_RB), 32'b0000100000);
        tick(); tick(); tick();
        chk("l3_wait_n4", 32'(if3.ioctl_wait), 32'd1);
        tick();
        chk("l3_wait_n5", 32'(if3.ioctl_wait), 32'd0);
        chk("l3_din", 32'(if3.ioctl_din), 32'h5A);

        if3.ioctl_addr = 25'h0000; if3.ioctl_rd = 1'b1;
        tick();
        if3.ioctl_rd = 1'b0;
        tick();
        chk("t5_cs_on", 32'(if3.CS_RB), 32'b0000000001);
        tick();
        chk("t5_in_wait", 32'(dbg3), 32'd2);
        if3.ioctl_upload = 1'b0;
        tick();
        chk("t5_abort_wait", 32'(if3.ioctl_wait), 32'd0);
        chk("t5_abort_cs", 32'(if3.CS_RB), 32'd0);
        chk("t5_abort_din", 32'(if3.ioctl_din), 32'h5A);
        chk("t5_abort_state", 32'(dbg3), 32'd0);
        if3.ioctl_upload = 1'b1;

`ifdef ROM_READBACK_CRC_EN
        // Restart the session, then one read of a zero byte.
        if1.ioctl_upload = 1'b0;
        tick();
        if1.ioctl_upload = 1'b1;
        tick();
        chk("t6_crc_init", 32'(if1.CRC), 32'hFFFF);
        read1("t6", 25'h1000, 10'b0000000010, 8'h00);
        chk("t6_crc", 32'(if1.CRC), 32'hE1F0);
        if1.ioctl_index = 8'd7; if1.ioctl_rd = 1'b1;
        tick();
        if1.ioctl_rd = 1'b0;
        tick(); tick(); tick();
        chk("t6_idx_cs", 32'(if1.CS_RB), 32'd0);
        chk("t6_idx_crc", 32'(if1.CRC), 32'hE1F0);
        if1.ioctl_index = 8'd0;
`else
        chk("crc_tied", 32'(if1.CRC), 32'hFFFF);
`endif

        // Asynchronous reset in the middle of a read.
        if1.ioctl_addr = 25'h9FFF; if1.ioctl_rd = 1'b1;
        tick();
        if1.ioctl_rd = 1'b0;
        tick();
        chk("mr_wait_pre", 32'(if1.ioctl_wait), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_din",   32'(if1.ioctl_din),  32'h00);
        chk("mr_wait",  32'(if1.ioctl_wait), 32'd0);
        chk("mr_addr",  32'(if1.ADDR_RB),    32'd0);
        chk("mr_cs",    32'(if1.CS_RB),      32'd0);
        chk("mr_crc",   32'(if1.CRC),        32'hFFFF);
        chk("mr_state", 32'(dbg1),           32'd0);
        chk("mr_din3",  32'(if3.ioctl_din),  32'h00);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
